// File: rtl/typing_tracker.sv
// Typing game tracker: checks released keys against a latched word, counting completed words and mistakes.
// Latency 1 cycle from key-release edge to outputs; no backpressure, wordReq high while idle and a word is wanted.
module typing_tracker #(
    parameter int MAX_LEN    = 8,
    parameter int LETTER_W   = 5,
    parameter int MAX_MISSES = 3,
    parameter int SCORE_W    = 8,
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic [MAX_LEN*LETTER_W-1:0]  currentWord,
    input  logic [LW-1:0]                wordLen,
    input  logic                         wordValid,
    input  logic [LETTER_W-1:0]          keystroke,
    input  logic                         keyReleased,
    output logic                         wordReq,
    output logic [LW-1:0]                letterIndex,
    output logic                         wordComplete,
    output logic                         mistake,
    output logic [7:0]                   missCount,
    output logic [SCORE_W-1:0]           score,
    output logic                         gameOver
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TYPING = 2'd1,
        OVER   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [MAX_LEN*LETTER_W-1:0]   word_q, word_d;
    logic [LW-1:0]                 len_q, len_d;
    logic [LW-1:0]                 idx_q, idx_d;
    logic                          key_prev_q;
    logic                          word_complete_q, word_complete_d;
    logic                          mistake_q, mistake_d;
    logic [7:0]                    miss_q, miss_d;
    logic [SCORE_W-1:0]            score_q, score_d;
    logic                          game_over_q, game_over_d;

    logic                          key_event;
    logic                          load_ok;
    logic [LW-1:0]                 len_clamped;
    logic [LETTER_W-1:0]           letters [MAX_LEN];
    logic [LETTER_W-1:0]           cur_letter;

    assign key_event   = keyReleased & ~key_prev_q;
    assign load_ok     = wordValid && (wordLen != '0) && (state_q != OVER);
    assign len_clamped = (wordLen > LW'(MAX_LEN)) ? LW'(MAX_LEN) : wordLen;

    // Letter 0 sits in the MSBs of the packed word.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            letters[i] = word_q[(MAX_LEN-i)*LETTER_W-1 -: LETTER_W];
        end
    end

    always_comb begin
        cur_letter = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LW'(i)) begin
                cur_letter = letters[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        len_d           = len_q;
        idx_d           = idx_q;
        word_complete_d = 1'b0;
        mistake_d       = 1'b0;
        miss_d          = miss_q;
        score_d         = score_q;
        game_over_d     = game_over_q;

        // A load wins over a simultaneous key event, which is dropped.
        if (load_ok) begin
            word_d  = currentWord;
            len_d   = len_clamped;
            idx_d   = '0;
            state_d = TYPING;
        end else begin
            case (state_q)
                IDLE: ;
                TYPING: begin
                    if (key_event) begin
                        if (keystroke == cur_letter) begin
                            if (idx_q == len_q - LW'(1)) begin
                                idx_d           = '0;
                                word_complete_d = 1'b1;
                                state_d         = IDLE;
                                if (!(&score_q)) begin
                                    score_d = score_q + SCORE_W'(1);
                                end
                            end else begin
                                idx_d = idx_q + LW'(1);
                            end
                        end else begin
                            mistake_d = 1'b1;
                            miss_d    = miss_q + 8'd1;
                            if (miss_q + 8'd1 == 8'(MAX_MISSES)) begin
                                state_d     = OVER;
                                game_over_d = 1'b1;
                            end
                        end
                    end
                end
                OVER: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q         <= IDLE;
            word_q          <= '0;
            len_q           <= '0;
            idx_q           <= '0;
            key_prev_q      <= 1'b0;
            word_complete_q <= 1'b0;
            mistake_q       <= 1'b0;
            miss_q          <= '0;
            score_q         <= '0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_q          <= word_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            key_prev_q      <= keyReleased;
            word_complete_q <= word_complete_d;
            mistake_q       <= mistake_d;
            miss_q          <= miss_d;
            score_q         <= score_d;
            game_over_q     <= game_over_d;
        end
    end

    assign wordReq      = (state_q == IDLE);
    assign letterIndex  = idx_q;
    assign wordComplete = word_complete_q;
    assign mistake      = mistake_q;
    assign missCount    = miss_q;
    assign score        = score_q;
    assign gameOver     = game_over_q;

endmodule

// File: tb/tb_typing_tracker.sv
// Directed bench for typing_tracker: default instance plus a 2-bit score instance sharing the same stimulus.
module tb_typing_tracker;

    localparam int MAX_LEN  = 8;
    localparam int LETTER_W = 5;
    localparam int LW       = 4;

    // Words as 5-bit code groups, placed in the upper 20 bits of the packed word.
    localparam logic [4:0] J = 5'b01010, O = 5'b10010, K = 5'b01011, E = 5'b00100;
    localparam logic [4:0] G = 5'b10000, A = 5'b00000, M = 5'b01100;
    localparam logic [4:0] BAD = 5'd23;
    localparam logic [19:0] JOKE = {J, O, K, E};
    localparam logic [19:0] GAME = {G, A, M, E};

    logic                         clk = 1'b0;
    logic                         rstN;
    logic [MAX_LEN*LETTER_W-1:0]  currentWord;
    logic [LW-1:0]                wordLen;
    logic                         wordValid;
    logic [LETTER_W-1:0]          keystroke;
    logic                         keyReleased;

    logic                         wordReq, wordComplete, mistake, gameOver;
    logic [LW-1:0]                letterIndex;
    logic [7:0]                   missCount;
    logic [7:0]                   score;

    logic                         s_wordReq, s_wordComplete, s_mistake, s_gameOver;
    logic [LW-1:0]                s_letterIndex;
    logic [7:0]                   s_missCount;
    logic [1:0]                   s_score;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    typing_tracker u_dut (
        .clk(clk), .rstN(rstN), .currentWord(currentWord), .wordLen(wordLen),
        .wordValid(wordValid), .keystroke(keystroke), .keyReleased(keyReleased),
        .wordReq(wordReq), .letterIndex(letterIndex), .wordComplete(wordComplete),
        .mistake(mistake), .missCount(missCount), .score(score), .gameOver(gameOver)
    );

    typing_tracker #(.SCORE_W(2)) u_sat (
        .clk(clk), .rstN(rstN), .currentWord(currentWord), .wordLen(wordLen),
        .wordValid(wordValid), .keystroke(keystroke), .keyReleased(keyReleased),
        .wordReq(s_wordReq), .letterIndex(s_letterIndex), .wordComplete(s_wordComplete),
        .mistake(s_mistake), .missCount(s_missCount), .score(s_score), .gameOver(s_gameOver)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        tick();
    endtask

    task automatic load(input logic [MAX_LEN*LETTER_W-1:0] w, input logic [LW-1:0] len);
        currentWord = w;
        wordLen     = len;
        wordValid   = 1'b1;
        tick();
        wordValid   = 1'b0;
    endtask

    // Low cycle first so the history register sees a fresh rising edge.
    task automatic key(input logic [4:0] k);
        keyReleased = 1'b0;
        tick();
        keystroke   = k;
        keyReleased = 1'b1;
        tick();
        keyReleased = 1'b0;
    endtask

    initial begin
        logic [MAX_LEN*LETTER_W-1:0] long_word;

        rstN = 1'b0; currentWord = '0; wordLen = '0; wordValid = 1'b0;
        keystroke = '0; keyReleased = 1'b0;
        #3;
        chk("rst_wordReq", wordReq, 1);
        chk("rst_idx", letterIndex, 0);
        chk("rst_wc", wordComplete, 0);
        chk("rst_mistake", mistake, 0);
        chk("rst_miss", missCount, 0);
        chk("rst_score", score, 0);
        chk("rst_over", gameOver, 0);
        tick();
        rstN = 1'b1;
        tick();

        // joke typed correctly
        load({JOKE, 20'b0}, 4'd4);
        chk("joke_load_req", wordReq, 0);
        chk("joke_load_idx", letterIndex, 0);
        key(J); chk("joke_idx1", letterIndex, 1);
        key(O); chk("joke_idx2", letterIndex, 2);
        key(K); chk("joke_idx3", letterIndex, 3);
        chk("joke_no_wc", wordComplete, 0);
        key(E);
        chk("joke_wc", wordComplete, 1);
        chk("joke_mistake", mistake, 0);
        chk("joke_score", score, 1);
        chk("joke_idx0", letterIndex, 0);
        chk("joke_req", wordReq, 1);
        tick();
        chk("joke_wc_pulse", wordComplete, 0);

        // game with one wrong key
        do_reset();
        load({GAME, 20'b0}, 4'd4);
        key(G); chk("game_idx1", letterIndex, 1);
        key(BAD);
        chk("game_mistake", mistake, 1);
        chk("game_miss", missCount, 1);
        chk("game_idx_hold", letterIndex, 1);
        chk("game_wc_excl", wordComplete, 0);
        tick();
        chk("game_mistake_pulse", mistake, 0);
        key(A); key(M); key(E);
        chk("game_wc", wordComplete, 1);
        chk("game_score", score, 1);
        chk("game_miss_keep", missCount, 1);

        // long key hold counts once
        do_reset();
        load({JOKE, 20'b0}, 4'd4);
        keystroke = J;
        keyReleased = 1'b1;
        repeat (10) tick();
        keyReleased = 1'b0;
        chk("hold_idx", letterIndex, 1);
        chk("hold_miss", missCount, 0);

        // load and key event together: load wins, word abandoned
        tick();
        currentWord = {GAME, 20'b0}; wordLen = 4'd4; wordValid = 1'b1;
        keystroke = 5'd31; keyReleased = 1'b1;
        tick();
        wordValid = 1'b0; keyReleased = 1'b0;
        chk("both_idx", letterIndex, 0);
        chk("both_mistake", mistake, 0);
        chk("both_miss", missCount, 0);
        chk("both_score", score, 0);
        key(G); chk("both_new_word", letterIndex, 1);

        // zero-length load ignored
        load({JOKE, 20'b0}, 4'd0);
        chk("len0_idx", letterIndex, 1);
        chk("len0_req", wordReq, 0);
        key(A); chk("len0_word_kept", letterIndex, 2);

        // overlong length clamps to MAX_LEN
        do_reset();
        long_word = '0;
        for (int i = 0; i < MAX_LEN; i++) long_word[(MAX_LEN-i)*LETTER_W-1 -: LETTER_W] = 5'(i + 1);
        load(long_word, 4'(MAX_LEN + 3));
        for (int i = 0; i < MAX_LEN - 1; i++) key(5'(i + 1));
        chk("clamp_idx7", letterIndex, 7);
        key(5'd8);
        chk("clamp_wc", wordComplete, 1);
        chk("clamp_score", score, 1);

        // three misses end the game
        do_reset();
        load({JOKE, 20'b0}, 4'd4);
        key(5'd31); chk("over_miss1", missCount, 1);
        key(5'd31); chk("over_miss2", missCount, 2);
        chk("over_not_yet", gameOver, 0);
        key(5'd26);
        chk("over_miss3", missCount, 3);
        chk("over_flag", gameOver, 1);
        chk("over_mistake", mistake, 1);
        load({GAME, 20'b0}, 4'd4);
        chk("over_req", wordReq, 0);
        key(J);
        chk("over_idx", letterIndex, 0);
        chk("over_miss_frozen", missCount, 3);
        chk("over_sticky", gameOver, 1);
        chk("over_no_mistake", mistake, 0);
        do_reset();
        chk("over_rst_req", wordReq, 1);
        chk("over_rst_miss", missCount, 0);
        chk("over_rst_flag", gameOver, 0);
        chk("over_rst_idx", letterIndex, 0);
        load({JOKE, 20'b0}, 4'd4);
        key(J); chk("post_rst_idx", letterIndex, 1);

        // score saturation on the 2-bit instance
        do_reset();
        for (int w = 0; w < 5; w++) begin
            load({JOKE, 20'b0}, 4'd4);
            key(J); key(O); key(K); key(E);
        end
        chk("sat_score2", s_score, 3);
        chk("sat_score8", score, 5);
        chk("sat_req", s_wordReq, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
